// File: rtl/interconnect_pkg.sv
// Shared definitions for the interconnect arbiters: default requester count
// and the grant FSM state encoding.
package interconnect_pkg;

  localparam int NUM_REQ_DEF  = 4;
  localparam int ID_WIDTH_DEF = $clog2(NUM_REQ_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority pick: the first set request at or after ptr_i,
// wrapping modulo NUM_REQ. Purely combinational.
module rr_priority_pick
  import interconnect_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] ptr_i,
  output logic                found_o,
  output logic [ID_WIDTH-1:0] idx_o
);

  logic [ID_WIDTH-1:0] cand;

  // Walk from the farthest offset to the nearest so the nearest set bit wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_WIDTH'((int'(ptr_i) + k) % NUM_REQ);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_fifo_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ packet
// sources; a grant is held until the last beat of the packet is accepted.
module rr_fifo_arbiter
  import interconnect_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = $clog2(NUM_REQ),
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_write_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [ID_WIDTH-1:0]           fifo_id,
  output logic                          grant_valid,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic [CNT_WIDTH-1:0]          grant_beats
);

  arb_state_e           state_q, state_d;
  logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]  grant_id_q, grant_id_d;
  logic [CNT_WIDTH-1:0] grant_beats_q, grant_beats_d;

  logic                  pick_found;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  accept;
  logic [DATA_WIDTH-1:0] req_slice [NUM_REQ];

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  // Explicit wrap so non-power-of-two requester counts return to 0.
  function automatic logic [ID_WIDTH-1:0] next_ptr(input logic [ID_WIDTH-1:0] id);
    return (id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign req_slice[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_priority_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign accept      = (state_q == GRANT) & req_valid[grant_id_q] & ~fifo_full;
  assign grant_id    = grant_id_q;
  assign grant_beats = grant_beats_q;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    grant_beats_d = grant_beats_q;
    req_ready     = '0;
    fifo_write_en = 1'b0;
    fifo_data_in  = '0;
    fifo_id       = '0;
    grant_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d    = pick_idx;
          grant_beats_d = '0;
          state_d       = GRANT;
        end
      end
      GRANT: begin
        grant_valid           = 1'b1;
        req_ready[grant_id_q] = ~fifo_full;
        fifo_write_en         = accept;
        fifo_data_in          = req_slice[grant_id_q];
        fifo_id               = grant_id_q;
        if (accept) begin
          grant_beats_d = sat_inc(grant_beats_q);
          if (req_last[grant_id_q]) begin
            rr_ptr_d = next_ptr(grant_id_q);
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      grant_beats_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      grant_beats_q <= grant_beats_d;
    end
  end

endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// Directed self-checking bench for rr_fifo_arbiter (4 requesters, 32-bit data).
module tb_rr_fifo_arbiter;

  logic         clk = 1'b0;
  logic         clr;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_last;
  logic [3:0]   req_ready;
  logic         fifo_full;
  logic         fifo_write_en;
  logic [31:0]  fifo_data_in;
  logic [1:0]   fifo_id;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic [7:0]   grant_beats;

  int n_cmp = 0;
  int n_err = 0;

  rr_fifo_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (32),
    .ID_WIDTH   (2),
    .CNT_WIDTH  (8)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .fifo_full     (fifo_full),
    .fifo_write_en (fifo_write_en),
    .fifo_data_in  (fifo_data_in),
    .fifo_id       (fifo_id),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id),
    .grant_beats   (grant_beats)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1-2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_d(input int i, input logic [31:0] v);
    req_data[i*32 +: 32] = v;
  endtask

  task automatic chk_grant(input string tag, input logic [1:0] id, input logic we,
                           input logic [31:0] d);
    chk({tag, ".gv"}, grant_valid, 1'b1);
    chk({tag, ".gid"}, grant_id, id);
    chk({tag, ".we"}, fifo_write_en, we);
    chk({tag, ".fid"}, fifo_id, id);
    chk({tag, ".data"}, fifo_data_in, d);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".gv"}, grant_valid, 1'b0);
    chk({tag, ".we"}, fifo_write_en, 1'b0);
    chk({tag, ".rdy"}, req_ready, 4'b0000);
    chk({tag, ".data"}, fifo_data_in, 32'h0);
    chk({tag, ".fid"}, fifo_id, 2'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] order [5];
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;

    clr = 1'b0; req_valid = 4'b1111; req_data = '0; req_last = 4'b1111; fifo_full = 1'b0;
    tick(); tick();
    chk_idle("reset");
    chk("reset.gid", grant_id, 2'd0);
    chk("reset.beats", grant_beats, 8'd0);
    req_valid = 4'b0000; req_last = 4'b0000;
    clr = 1'b1;
    tick();

    // Single requester 2, three beats A0..A2
    req_valid = 4'b0100; set_d(2, 32'hA0); settle();
    chk_idle("t1.idle");
    tick(); settle();
    chk_grant("t1.b0", 2'd2, 1'b1, 32'hA0);
    chk("t1.b0.rdy", req_ready, 4'b0100);
    chk("t1.b0.beats", grant_beats, 8'd0);
    tick(); set_d(2, 32'hA1); settle();
    chk_grant("t1.b1", 2'd2, 1'b1, 32'hA1);
    chk("t1.b1.beats", grant_beats, 8'd1);
    tick(); set_d(2, 32'hA2); req_last = 4'b0100; settle();
    chk_grant("t1.b2", 2'd2, 1'b1, 32'hA2);
    chk("t1.b2.beats", grant_beats, 8'd2);
    tick(); req_valid = 4'b0000; req_last = 4'b0000; settle();
    chk_idle("t1.done");
    chk("t1.done.beats", grant_beats, 8'd3);

    // Wrap: pointer now 3, requesters 0 and 3 valid with one-beat packets
    req_valid = 4'b1001; req_last = 4'b1001; set_d(0, 32'hB0); set_d(3, 32'hB3);
    tick(); settle();
    chk_grant("wrap.g3", 2'd3, 1'b1, 32'hB3);
    chk("wrap.g3.beats", grant_beats, 8'd0);
    tick(); settle();
    chk_idle("wrap.gap");
    tick(); settle();
    chk_grant("wrap.g0", 2'd0, 1'b1, 32'hB0);
    tick(); req_valid = 4'b0000; req_last = 4'b0000; settle();
    chk_idle("wrap.done");

    // Backpressure: pointer now 1, requester 1 three beats, full for 4 cycles on beat 2
    req_valid = 4'b0010; set_d(1, 32'hC0);
    tick(); settle();
    chk_grant("bp.b0", 2'd1, 1'b1, 32'hC0);
    tick(); set_d(1, 32'hC1); fifo_full = 1'b1; settle();
    for (int i = 0; i < 4; i++) begin
      chk("bp.full.we", fifo_write_en, 1'b0);
      chk("bp.full.rdy", req_ready, 4'b0000);
      chk("bp.full.gv", grant_valid, 1'b1);
      chk("bp.full.beats", grant_beats, 8'd1);
      tick();
    end
    fifo_full = 1'b0; settle();
    chk_grant("bp.b1", 2'd1, 1'b1, 32'hC1);
    chk("bp.b1.rdy", req_ready, 4'b0010);
    chk("bp.b1.beats", grant_beats, 8'd1);
    tick(); set_d(1, 32'hC2); req_last = 4'b0010; settle();
    chk_grant("bp.b2", 2'd1, 1'b1, 32'hC2);
    tick(); req_valid = 4'b0000; req_last = 4'b0000; settle();
    chk_idle("bp.done");
    chk("bp.done.beats", grant_beats, 8'd3);

    // Bubble: pointer now 2, requester 2 drops valid while requester 1 waits
    req_valid = 4'b0100; set_d(2, 32'hD0); set_d(1, 32'hE1);
    tick(); settle();
    chk_grant("bub.b0", 2'd2, 1'b1, 32'hD0);
    tick(); req_valid = 4'b0010; req_last = 4'b0010; set_d(2, 32'hD1); settle();
    for (int i = 0; i < 2; i++) begin
      chk_grant("bub.hole", 2'd2, 1'b0, 32'hD1);
      chk("bub.hole.rdy", req_ready, 4'b0100);
      tick();
    end
    req_valid = 4'b0110; req_last = 4'b0110; settle();
    chk_grant("bub.b1", 2'd2, 1'b1, 32'hD1);
    tick(); req_valid = 4'b0010; settle();
    chk_idle("bub.gap");
    chk("bub.gap.beats", grant_beats, 8'd2);
    tick(); settle();
    chk_grant("bub.r1", 2'd1, 1'b1, 32'hE1);
    tick(); req_valid = 4'b0000; req_last = 4'b0000; settle();
    chk_idle("bub.done");

    // Async reset on beat 2 of a 4-beat packet from requester 3
    req_valid = 4'b1000; set_d(3, 32'hF0);
    tick(); settle();
    chk_grant("rst.b0", 2'd3, 1'b1, 32'hF0);
    tick(); set_d(3, 32'hF1); settle();
    chk("rst.b1.beats", grant_beats, 8'd1);
    clr = 1'b0; settle();
    chk_idle("rst.asserted");
    chk("rst.asserted.gid", grant_id, 2'd0);
    chk("rst.asserted.beats", grant_beats, 8'd0);
    clr = 1'b1;
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int i = 0; i < 4; i++) set_d(i, 32'h100 + i);
    settle();
    chk_idle("rst.released");

    // Fairness from pointer 0: one-beat packets from all four
    for (int k = 0; k < 5; k++) begin
      tick(); settle();
      chk_grant($sformatf("fair%0d", k), order[k], 1'b1, 32'h100 + 32'(order[k]));
      tick(); settle();
      chk("fair.gap.gv", grant_valid, 1'b0);
    end
    req_valid = 4'b0000; req_last = 4'b0000;

    // Beat counter saturation: pointer now 1, long packet from requester 1
    tick(); req_valid = 4'b0010;
    tick(); settle();
    chk("sat.start.gid", grant_id, 2'd1);
    for (int i = 0; i < 258; i++) tick();
    settle();
    chk("sat.beats", grant_beats, 8'd255);
    chk("sat.gv", grant_valid, 1'b1);
    req_last = 4'b0010;
    tick(); req_valid = 4'b0000; req_last = 4'b0000; settle();
    chk("sat.end.gv", grant_valid, 1'b0);
    chk("sat.end.beats", grant_beats, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
